// File: rtl/fetch_pkg.sv
// Shared types and constants for the femtoRV32 instruction-fetch stage.
package fetch_pkg;
    localparam int          XLEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, RUN, BUBBLE} fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] inst;
    } ifid_t;
endpackage

// File: rtl/pc_reg.sv
// Program counter flop with next-PC selection: sequential +4 or word-aligned redirect target.
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_o
);
    logic [XLEN-1:0] pc_q, pc_d;

    // Targets are forced word-aligned; misaligned low bits are dropped without a trap.
    assign pc_d = redirect_i ? (redirect_pc_i & ~XLEN'(3)) : pc_q + XLEN'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       pc_q <= RESET_PC;
        else if (en_i) pc_q <= pc_d;
    end

    assign pc_o = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, ROM addressing, IF/ID register, boot/redirect bubble FSM.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          AW       = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_data,
    output logic          ifid_valid,
    output logic [31:0]   ifid_pc,
    output logic [31:0]   ifid_pc4,
    output logic [31:0]   ifid_inst
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_bubbles
`endif
);
    localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, pc: '0, pc4: '0, inst: NOP_INST};

    fetch_state_t state_q, state_d;
    ifid_t        ifid_q, ifid_d;
    logic [31:0]  pc, pc4;
    logic         fetch_we, bubble_we, pc_en;

    // BOOT holds the PC so the first real fetch is from RESET_PC one edge later.
    assign pc_en = (state_q != BOOT) && (!stall || redirect);

    pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk          (clk),
        .rst          (rst),
        .en_i         (pc_en),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .pc_o         (pc)
    );

    assign pc4       = pc + 32'd4;
    assign imem_addr = pc[AW+1:2];

    always_comb begin
        state_d   = state_q;
        fetch_we  = 1'b0;
        bubble_we = 1'b0;
        case (state_q)
            BOOT: begin
                state_d   = RUN;
                bubble_we = 1'b1;
            end
            default: begin
                if (redirect) begin
                    state_d   = BUBBLE;
                    bubble_we = 1'b1;
                end else if (!stall) begin
                    state_d  = RUN;
                    fetch_we = 1'b1;
                end
            end
        endcase
        ifid_d = ifid_q;
        if (bubble_we) ifid_d = IFID_BUBBLE;
        if (fetch_we)  ifid_d = '{valid: 1'b1, pc: pc, pc4: pc4, inst: imem_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            ifid_q  <= IFID_BUBBLE;
        end else begin
            state_q <= state_d;
            ifid_q  <= ifid_d;
        end
    end

    assign ifid_valid = ifid_q.valid;
    assign ifid_pc    = ifid_q.pc;
    assign ifid_pc4   = ifid_q.pc4;
    assign ifid_inst  = ifid_q.inst;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, bubbles_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            if (fetch_we)  fetched_q <= fetched_q + 32'd1;
            if (bubble_we) bubbles_q <= bubbles_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`endif
endmodule
